// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, FSM
// states, datapath mux selects and the bundle of registered control strobes.
package mips_ctrl_pkg;

    // Opcode field values (IR[31:26]) understood by the sequencer
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // ALU operand-B selects
    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_I_EXEC   = 4'd9,
        S_I_WB     = 4'd10,
        S_JUMP     = 4'd11,
        S_TRAP     = 4'd15
    } state_e;

    typedef enum logic [2:0] {
        ALU_SUB   = 3'b000,
        ALU_AND   = 3'b001,
        ALU_ADD   = 3'b011,
        ALU_LUI   = 3'b100,
        ALU_OR    = 3'b101,
        ALU_ADDI  = 3'b110,
        ALU_FUNCT = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        PC_ALU    = 2'b00,
        PC_ALUOUT = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_e;

    typedef enum logic [1:0] {
        RD_RT = 2'b00,
        RD_RD = 2'b01,
        RD_RA = 2'b10
    } reg_dst_e;

    typedef enum logic [1:0] {
        WD_ALUOUT = 2'b00,
        WD_MDR    = 2'b01,
        WD_PC     = 2'b10
    } mem_to_reg_e;

    // Registered (Moore) control strobes; the FETCH handshake terms are
    // added combinationally in the top level.
    typedef struct packed {
        logic        pc_write;
        logic        branch_eq;
        logic        branch_ne;
        logic        iord;
        logic        mem_read;
        logic        mem_write;
        reg_dst_e    reg_dst;
        mem_to_reg_e mem_to_reg;
        logic        reg_write;
        logic        alu_src_a;
        logic [1:0]  alu_src_b;
        logic        zero_ext;
        alu_op_e     alu_op;
        pc_src_e     pc_source;
        logic        trap;
    } ctrl_t;

    // Control word a state presents to the datapath, given the latched opcode
    function automatic ctrl_t ctrl_for(input state_e s, input logic [5:0] op);
        ctrl_t c;
        c            = '0;
        c.reg_dst    = RD_RT;
        c.mem_to_reg = WD_ALUOUT;
        c.alu_op     = ALU_SUB;
        c.pc_source  = PC_ALU;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = SRCB_FOUR;
                c.alu_op    = ALU_ADD;
            end
            S_DECODE: begin
                c.alu_src_b = SRCB_BRANCH;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            S_MEM_WB: begin
                c.mem_to_reg = WD_MDR;
                c.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            S_R_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALU_FUNCT;
            end
            S_R_WB: begin
                c.reg_dst   = RD_RD;
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_REG;
                c.alu_op    = ALU_SUB;
                c.pc_source = PC_ALUOUT;
                c.branch_eq = (op == OP_BEQ);
                c.branch_ne = (op == OP_BNE);
            end
            S_I_EXEC: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRCB_IMM;
                case (op)
                    OP_ADDI: c.alu_op = ALU_ADDI;
                    OP_ORI: begin
                        c.alu_op   = ALU_OR;
                        c.zero_ext = 1'b1;
                    end
                    OP_ANDI: begin
                        c.alu_op   = ALU_AND;
                        c.zero_ext = 1'b1;
                    end
                    OP_LUI:  c.alu_op = ALU_LUI;
                    default: c.alu_op = ALU_SUB;
                endcase
            end
            S_I_WB: begin
                c.reg_write = 1'b1;
            end
            S_JUMP: begin
                c.pc_source = PC_JUMP;
                c.pc_write  = 1'b1;
                if (op == OP_JAL) begin
                    c.reg_write  = 1'b1;
                    c.reg_dst    = RD_RA;
                    c.mem_to_reg = WD_PC;
                end
            end
            default: begin
                c.trap = 1'b1;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: increments when enabled, wraps modulo 2^WIDTH,
// cleared asynchronously.
module retire_counter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: natural overflow gives the wrap
    assign count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            count_q <= '0;
        end else if (en_i) begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for a multi-cycle MIPS datapath with a shared
// instruction/data memory. Control strobes are registered alongside the state;
// only the FETCH handshake (IRWrite, PCWrite) follows MemReady directly.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH     = 32,
    parameter bit          MEM_HANDSHAKE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           OP,
    input  logic                 MemReady,
    output logic                 PCWrite,
    output logic                 BranchEQ,
    output logic                 BranchNE,
    output logic                 IorD,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           RegDst,
    output logic [1:0]           MemtoReg,
    output logic                 RegWrite,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic                 ZeroExt,
    output logic [2:0]           ALUOp,
    output logic [1:0]           PCSource,
    output logic                 Trap,
    output logic [3:0]           State,
    output logic [CNT_WIDTH-1:0] Retired
);

    state_e      state_q;
    state_e      state_d;
    logic [5:0]  opcode_q;
    logic [5:0]  opcode_d;
    ctrl_t       ctrl_q;
    ctrl_t       ctrl_d;
    logic        mem_ready;
    logic        fetch_strobe;
    logic        retire_en;

    assign mem_ready = MEM_HANDSHAKE ? MemReady : 1'b1;

    // Next-state and opcode-latch logic
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no latch is inferred.
        state_d  = state_q;
        opcode_d = opcode_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                opcode_d = OP;
                case (OP)
                    OP_RTYPE:                        state_d = S_R_EXEC;
                    OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
                    OP_ADDI, OP_ORI, OP_ANDI, OP_LUI: state_d = S_I_EXEC;
                    OP_BEQ, OP_BNE:                  state_d = S_BRANCH;
                    OP_J, OP_JAL:                    state_d = S_JUMP;
                    default:                         state_d = S_TRAP;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode_q == OP_LW)      state_d = S_MEM_RD;
                else if (opcode_q == OP_SW) state_d = S_MEM_WR;
                else                        state_d = S_TRAP;
            end
            S_MEM_RD: begin
                if (mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WR: begin
                if (mem_ready) state_d = S_FETCH;
            end
            S_MEM_WB: state_d = S_FETCH;
            S_R_EXEC: state_d = S_R_WB;
            S_R_WB:   state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_I_EXEC: state_d = S_I_WB;
            S_I_WB:   state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            // TRAP is absorbing; unused encodings also land here
            default:  state_d = S_TRAP;
        endcase
    end

    // Control word for the state being entered, so outputs come straight from flops
    assign ctrl_d = ctrl_for(state_d, opcode_d);

    // State, latched opcode and registered control strobes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            opcode_q <= '0;
            ctrl_q   <= ctrl_for(S_FETCH, 6'h00);
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            ctrl_q   <= ctrl_d;
        end
    end

    // Instruction retires on every entry into FETCH from another state
    assign retire_en = (state_d == S_FETCH) && (state_q != S_FETCH);

    retire_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_retire_counter (
        .clk     (clk),
        .rst_n   (reset),
        .en_i    (retire_en),
        .count_o (Retired)
    );

    // FETCH handshake: IR and PC load in the cycle memory delivers the word
    assign fetch_strobe = (state_q == S_FETCH) && mem_ready;

    assign PCWrite  = ctrl_q.pc_write | fetch_strobe;
    assign IRWrite  = fetch_strobe;
    assign BranchEQ = ctrl_q.branch_eq;
    assign BranchNE = ctrl_q.branch_ne;
    assign IorD     = ctrl_q.iord;
    assign MemRead  = ctrl_q.mem_read;
    assign MemWrite = ctrl_q.mem_write;
    assign RegDst   = ctrl_q.reg_dst;
    assign MemtoReg = ctrl_q.mem_to_reg;
    assign RegWrite = ctrl_q.reg_write;
    assign ALUSrcA  = ctrl_q.alu_src_a;
    assign ALUSrcB  = ctrl_q.alu_src_b;
    assign ZeroExt  = ctrl_q.zero_ext;
    assign ALUOp    = ctrl_q.alu_op;
    assign PCSource = ctrl_q.pc_source;
    assign Trap     = ctrl_q.trap;
    assign State    = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks LW, stalled SW, branches,
// JAL, ORI, R-type, a mid-store reset and an illegal-opcode trap.
module tb_multicycle_control;

    logic        clk;
    logic        reset;
    logic [5:0]  OP;
    logic        MemReady;
    logic        PCWrite, BranchEQ, BranchNE, IorD, MemRead, MemWrite, IRWrite;
    logic [1:0]  RegDst, MemtoReg, ALUSrcB, PCSource;
    logic        RegWrite, ALUSrcA, ZeroExt, Trap;
    logic [2:0]  ALUOp;
    logic [3:0]  State;
    logic [31:0] Retired;

    int n_assert = 0;
    int n_fail   = 0;

    multicycle_control #(
        .CNT_WIDTH     (32),
        .MEM_HANDSHAKE (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .OP       (OP),
        .MemReady (MemReady),
        .PCWrite  (PCWrite),
        .BranchEQ (BranchEQ),
        .BranchNE (BranchNE),
        .IorD     (IorD),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ZeroExt  (ZeroExt),
        .ALUOp    (ALUOp),
        .PCSource (PCSource),
        .Trap     (Trap),
        .State    (State),
        .Retired  (Retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b0;
        OP       = 6'h00;
        MemReady = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_state",   32'(State), 32'd0);
        check("rst_retired", Retired, 32'd0);
        check("rst_trap",    32'(Trap), 32'd0);
        check("rst_memread", 32'(MemRead), 32'd1);
        check("rst_irwrite", 32'(IRWrite), 32'd0);
        check("rst_pcwrite", 32'(PCWrite), 32'd0);
        check("rst_alusrcb", 32'(ALUSrcB), 32'd1);
        check("rst_aluop",   32'(ALUOp), 32'd3);
        reset = 1'b1;
        tick();
        check("fetch_wait", 32'(State), 32'd0);

        // LW with memory ready: 0,1,2,3,4,0
        OP = 6'h23; MemReady = 1'b1; #1;
        check("lw_irwrite", 32'(IRWrite), 32'd1);
        check("lw_pcwrite", 32'(PCWrite), 32'd1);
        tick();
        check("lw_s1",         32'(State), 32'd1);
        check("lw_dec_alusrcb",32'(ALUSrcB), 32'd3);
        check("lw_dec_regwr",  32'(RegWrite), 32'd0);
        tick();
        check("lw_s2",         32'(State), 32'd2);
        check("lw_addr_srca",  32'(ALUSrcA), 32'd1);
        check("lw_addr_srcb",  32'(ALUSrcB), 32'd2);
        tick();
        check("lw_s3",         32'(State), 32'd3);
        check("lw_rd_iord",    32'(IorD), 32'd1);
        check("lw_rd_memread", 32'(MemRead), 32'd1);
        check("lw_rd_regwr",   32'(RegWrite), 32'd0);
        tick();
        check("lw_s4",         32'(State), 32'd4);
        check("lw_wb_regwr",   32'(RegWrite), 32'd1);
        check("lw_wb_mtr",     32'(MemtoReg), 32'd1);
        check("lw_wb_regdst",  32'(RegDst), 32'd0);
        tick();
        check("lw_s0",         32'(State), 32'd0);
        check("lw_retired",    Retired, 32'd1);

        // SW with three stalled cycles in MEM_WR
        OP = 6'h2B;
        tick();
        tick();
        check("sw_s2", 32'(State), 32'd2);
        MemReady = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("sw_wr_state",    32'(State), 32'd5);
            check("sw_wr_memwrite", 32'(MemWrite), 32'd1);
            check("sw_wr_memread",  32'(MemRead), 32'd0);
            check("sw_wr_iord",     32'(IorD), 32'd1);
            check("sw_wr_regwr",    32'(RegWrite), 32'd0);
            if (i == 3) MemReady = 1'b1;
            tick();
        end
        check("sw_s0",      32'(State), 32'd0);
        check("sw_retired", Retired, 32'd2);

        // BNE
        OP = 6'h05;
        tick();
        tick();
        check("bne_s8",       32'(State), 32'd8);
        check("bne_branchne", 32'(BranchNE), 32'd1);
        check("bne_brancheq", 32'(BranchEQ), 32'd0);
        check("bne_pcsource", 32'(PCSource), 32'd1);
        check("bne_aluop",    32'(ALUOp), 32'd0);
        check("bne_pcwrite",  32'(PCWrite), 32'd0);
        tick();
        check("bne_retired",  Retired, 32'd3);

        // BEQ
        OP = 6'h04;
        tick();
        tick();
        check("beq_s8",       32'(State), 32'd8);
        check("beq_brancheq", 32'(BranchEQ), 32'd1);
        check("beq_branchne", 32'(BranchNE), 32'd0);
        tick();
        check("beq_retired",  Retired, 32'd4);

        // JAL
        OP = 6'h03;
        tick();
        tick();
        check("jal_s11",      32'(State), 32'd11);
        check("jal_pcwrite",  32'(PCWrite), 32'd1);
        check("jal_pcsource", 32'(PCSource), 32'd2);
        check("jal_regwr",    32'(RegWrite), 32'd1);
        check("jal_regdst",   32'(RegDst), 32'd2);
        check("jal_mtr",      32'(MemtoReg), 32'd2);
        tick();
        check("jal_s0",       32'(State), 32'd0);
        check("jal_retired",  Retired, 32'd5);

        // ORI
        OP = 6'h0D;
        tick();
        tick();
        check("ori_s9",      32'(State), 32'd9);
        check("ori_aluop",   32'(ALUOp), 32'd5);
        check("ori_zeroext", 32'(ZeroExt), 32'd1);
        check("ori_alusrcb", 32'(ALUSrcB), 32'd2);
        tick();
        check("ori_s10",     32'(State), 32'd10);
        check("ori_regwr",   32'(RegWrite), 32'd1);
        check("ori_zext_off",32'(ZeroExt), 32'd0);
        tick();
        check("ori_retired", Retired, 32'd6);

        // R-type
        OP = 6'h00;
        tick();
        tick();
        check("r_s6",      32'(State), 32'd6);
        check("r_aluop",   32'(ALUOp), 32'd7);
        check("r_alusrcb", 32'(ALUSrcB), 32'd0);
        tick();
        check("r_s7",      32'(State), 32'd7);
        check("r_regdst",  32'(RegDst), 32'd1);
        check("r_regwr",   32'(RegWrite), 32'd1);
        tick();
        check("r_retired", Retired, 32'd7);

        // Reset in the middle of a store
        OP = 6'h2B;
        tick();
        tick();
        MemReady = 1'b0;
        tick();
        check("mid_memwrite", 32'(MemWrite), 32'd1);
        reset = 1'b0; #1;
        check("mid_rst_state",    32'(State), 32'd0);
        check("mid_rst_memwrite", 32'(MemWrite), 32'd0);
        check("mid_rst_retired",  Retired, 32'd0);
        tick();
        reset = 1'b1;
        tick();
        check("mid_post_state",   32'(State), 32'd0);
        check("mid_post_memread", 32'(MemRead), 32'd1);
        check("mid_post_memwrite",32'(MemWrite), 32'd0);

        // Illegal opcode traps and stays trapped
        OP = 6'h3F; MemReady = 1'b1;
        tick();
        check("trap_s1", 32'(State), 32'd1);
        tick();
        for (int i = 0; i < 20; i++) begin
            check("trap_state",    32'(State), 32'd15);
            check("trap_flag",     32'(Trap), 32'd1);
            check("trap_memread",  32'(MemRead), 32'd0);
            check("trap_memwrite", 32'(MemWrite), 32'd0);
            check("trap_regwr",    32'(RegWrite), 32'd0);
            check("trap_pcwrite",  32'(PCWrite), 32'd0);
            check("trap_irwrite",  32'(IRWrite), 32'd0);
            check("trap_retired",  Retired, 32'd0);
            tick();
        end
        reset = 1'b0; #1;
        check("trap_clr_flag",  32'(Trap), 32'd0);
        check("trap_clr_state", 32'(State), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style sequencing FSM for a multi-cycle MIPS datapath with a shared instruction/data memory.
- Drives PC, IR, memory, register-file and ALU-mux enables for: R-type, ADDI, ORI, ANDI, LUI, LW, SW, BEQ, BNE, J, JAL.
- Waits on a memory-ready handshake, traps on illegal opcodes, and counts retired instructions.
- Sits beside the datapath top, replacing single-cycle opcode decode.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter
MEM_HANDSHAKE, 1, 1 = honour MemReady; 0 = treat MemReady as constant 1

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
OP  input  6  opcode field of the instruction register (IR[31:26])
MemReady  input  1  memory completes the current read/write this cycle
PCWrite  output  1  unconditional PC load
BranchEQ  output  1  PC load if ALU Zero=1
BranchNE  output  1  PC load if ALU Zero=0
IorD  output  1  memory address: 0 = PC, 1 = ALUOut
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
IRWrite  output  1  instruction register load
RegDst  output  2  write register: 00 = rt, 01 = rd, 10 = $31
MemtoReg  output  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC
RegWrite  output  1  register-file write enable
ALUSrcA  output  1  0 = PC, 1 = register A
ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = ext(imm), 11 = sext(imm)<<2
ZeroExt  output  1  immediate extender zero-extends (ORI, ANDI)
ALUOp  output  3  111 R-type(funct), 110 add(ADDI), 101 or, 100 lui, 011 add, 001 and, 000 sub
PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target
Trap  output  1  illegal opcode seen; core halted
State  output  4  current state, for debug
Retired  output  CNT_WIDTH  retired-instruction count

Behaviour:
- States: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, I_EXEC=9, I_WB=10, JUMP=11, TRAP=15. Codes 12-14 go to TRAP.
- Reset (reset=0, asynchronous): state=FETCH, latched opcode=0, Retired=0, Trap=0. All outputs take their FETCH values; handshake strobes are 0 until MemReady.
- All outputs not listed for a state are 0.
- FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=011, PCSource=00.
  - IRWrite=PCWrite=MemReady (the only Mealy terms).
  - Stays in FETCH while MemReady=0; otherwise goes to DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=011 (branch target into ALUOut). OP is latched into the opcode register. Next state by OP:
  - 0x00 -> R_EXEC
  - 0x23 or 0x2B -> MEM_ADDR
  - 0x08, 0x0D, 0x0C, 0x0F -> I_EXEC
  - 0x04 or 0x05 -> BRANCH
  - 0x02 or 0x03 -> JUMP
  - any other value -> TRAP
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=011. Next: LW -> MEM_RD, SW -> MEM_WR.
- MEM_RD: IorD=1, MemRead=1. Holds until MemReady=1, then MEM_WB.
- MEM_WB: RegDst=00, MemtoReg=01, RegWrite=1 -> FETCH.
- MEM_WR: IorD=1, MemWrite=1. Holds until MemReady=1, then FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=111 -> R_WB.
- R_WB: RegDst=01, RegWrite=1 -> FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10; ALUOp per latched opcode (ADDI 110, ORI 101, LUI 100, ANDI 001); ZeroExt=1 for ORI/ANDI -> I_WB.
- I_WB: RegDst=00, MemtoReg=00, RegWrite=1 -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=000, PCSource=01. BranchEQ=1 for BEQ, BranchNE=1 for BNE -> FETCH.
- JUMP: PCSource=10, PCWrite=1. For JAL also RegWrite=1, RegDst=10, MemtoReg=10 (PC already +4) -> FETCH.
- TRAP: Trap=1, all strobes 0, absorbing until reset.
- MemRead and MemWrite are never both 1.
- Retired increments by 1 on every transition into FETCH from a state other than FETCH; it wraps modulo 2^CNT_WIDTH.
- Latency with MemReady held at 1:
  - J/JAL/BEQ/BNE: 3 cycles
  - R-type/I-ALU/SW: 4 cycles
  - LW: 5 cycles
  - Each MemReady=0 cycle in FETCH/MEM_RD/MEM_WR adds one cycle.
- Reset mid-instruction aborts immediately; there is no partial write after reset rises.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - opcode constants
  - state encodings
  - ALUOp, PCSource, RegDst and MemtoReg encodings
- Sub-module retire_counter (enable, async active-low clear, wrap) is natural; everything else stays in one module.

Test Plan:
- Reset=0 mid-MEM_WR (MemWrite=1), release -> State=0, MemWrite=0, Retired=0, MemRead=1 next cycle.
- OP=0x23, MemReady=1 -> states 0,1,2,3,4,0; RegWrite=1 only in state 4 with MemtoReg=01; Retired +1 after 5 cycles.
- OP=0x2B, MemReady=0 for 3 cycles in MEM_WR -> MemWrite held 4 cycles, IorD=1, no RegWrite; FETCH follows.
- OP=0x05 -> BRANCH state asserts BranchNE=1, BranchEQ=0, PCSource=01, ALUOp=000; OP=0x04 asserts BranchEQ only.
- OP=0x03 -> JUMP asserts PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10.
- OP=0x3F -> DECODE then TRAP; Trap=1 stays with all strobes 0 for 20 cycles; Retired unchanged; reset clears Trap.
